// File: rtl/tank_sprite_renderer.sv
// tank_sprite_renderer
//   Per-pixel sprite lookup for one tank. It sits between the VGA scan
//   counter and the colour mapper. The block decides whether the scan
//   coordinate lies inside the tank's magnified on-screen box. It then
//   forms a sprite ROM address and registers the palette index that comes
//   back. Position, direction, alive state and the animation phase are
//   latched only on frame_start, so a sprite never tears mid-scan.
//
//   Parameters
//     SCALE_SHIFT  magnification as a power of two; box = 16<<SCALE_SHIFT px
//     ANIM_PERIOD  video frames per track-animation toggle while moving (>=1)
//
//   Ports
//     Clk          in   pixel clock
//     Reset        in   synchronous, active-high
//     frame_start  in   one-cycle pulse at start of vertical blank
//     DrawX/DrawY  in   current scan column/row (10 bits)
//     tank_x/y     in   box top-left column/row (10 bits)
//     tank_dir     in   0 left, 1 up, 2 right, 3 down
//     tank_moving  in   tank moved this frame
//     tank_alive   in   0 suppresses drawing
//     rom_row      out  sprite ROM row {dir, anim, sy}, combinational from stage 1
//     rom_col      out  sprite ROM column sx, combinational from stage 1
//     rom_data     in   ROM entry at {rom_row, rom_col}, combinational
//     pixel_hit    out  registered; 1 = opaque tank pixel (2-cycle latency)
//     pixel_index  out  registered palette index, 0 when pixel_hit = 0
module tank_sprite_renderer #(
    parameter int SCALE_SHIFT = 1,
    parameter int ANIM_PERIOD = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] tank_x,
    input  logic [9:0] tank_y,
    input  logic [1:0] tank_dir,
    input  logic       tank_moving,
    input  logic       tank_alive,
    output logic [6:0] rom_row,
    output logic [3:0] rom_col,
    input  logic [4:0] rom_data,
    output logic       pixel_hit,
    output logic [4:0] pixel_index
);

    localparam int              BOX      = 16 << SCALE_SHIFT;
    localparam logic [10:0]     BOX_W    = 11'(BOX);
    localparam int              CNT_W    = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_PERIOD - 1);

    // Inside-box test on 11-bit differences. Bit 10 is the borrow, so a
    // coordinate left of / above the box never aliases into it. Nothing
    // wraps past the right or bottom screen edge.
    function automatic logic box_hit(input logic       alive,
                                     input logic [10:0] dx,
                                     input logic [10:0] dy);
        return alive & ~dx[10] & ~dy[10] & (dx < BOX_W) & (dy < BOX_W);
    endfunction

    // Frame-latched state
    logic [9:0]       pos_x_q, pos_y_q;
    logic [1:0]       dir_q;
    logic             alive_q;
    logic             moving_q;
    logic [CNT_W-1:0] anim_cnt_q, anim_cnt_d;
    logic             anim_q, anim_d;

    // Stage 1 registers
    logic             in_box_p1_q;
    logic [3:0]       sx_p1_q, sy_p1_q;
    logic [1:0]       dir_p1_q;
    logic             anim_p1_q;

    // Stage 2 (output) registers
    logic             hit_p2_q;
    logic [4:0]       index_p2_q;

    logic [10:0]      dx_d, dy_d;
    logic             in_box_d;
    logic [3:0]       sx_d, sy_d;
    logic             hit_d;
    logic [4:0]       index_d;

    assign dx_d     = {1'b0, DrawX} - {1'b0, pos_x_q};
    assign dy_d     = {1'b0, DrawY} - {1'b0, pos_y_q};
    assign in_box_d = box_hit(alive_q, dx_d, dy_d);
    // Downscale to sprite texels. The upper bits of dx/dy are only needed
    // for the bounds test above.
    assign sx_d     = dx_d[SCALE_SHIFT +: 4];
    assign sy_d     = dy_d[SCALE_SHIFT +: 4];

    // Animation advances only on frame_start, and only on the moving flag
    // latched on the previous frame_start.
    always_comb begin
        anim_cnt_d = anim_cnt_q;
        anim_d     = anim_q;
        if (frame_start && moving_q) begin
            if (anim_cnt_q == CNT_LAST) begin
                anim_cnt_d = '0;
                anim_d     = ~anim_q;
            end else begin
                anim_cnt_d = anim_cnt_q + 1'b1;
            end
        end
    end

    // The ROM address is forced to 0 while Reset is held, including the
    // cycles before the first reset edge.
    assign rom_row = Reset ? 7'd0 : {dir_p1_q, anim_p1_q, sy_p1_q};
    assign rom_col = Reset ? 4'd0 : sx_p1_q;

    assign hit_d   = in_box_p1_q & (rom_data != 5'd0);
    assign index_d = hit_d ? rom_data : 5'd0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            dir_q       <= '0;
            alive_q     <= 1'b0;
            moving_q    <= 1'b0;
            anim_cnt_q  <= '0;
            anim_q      <= 1'b0;
            in_box_p1_q <= 1'b0;
            sx_p1_q     <= '0;
            sy_p1_q     <= '0;
            dir_p1_q    <= '0;
            anim_p1_q   <= 1'b0;
            hit_p2_q    <= 1'b0;
            index_p2_q  <= '0;
        end else begin
            if (frame_start) begin
                pos_x_q  <= tank_x;
                pos_y_q  <= tank_y;
                dir_q    <= tank_dir;
                alive_q  <= tank_alive;
                moving_q <= tank_moving;
            end
            anim_cnt_q  <= anim_cnt_d;
            anim_q      <= anim_d;
            // ---- stage 1: box test and texel address (pre-update latches) ----
            in_box_p1_q <= in_box_d;
            sx_p1_q     <= sx_d;
            sy_p1_q     <= sy_d;
            dir_p1_q    <= dir_q;
            anim_p1_q   <= anim_q;
            // ---- stage 2: ROM data qualified by box and transparency ----
            hit_p2_q    <= hit_d;
            index_p2_q  <= index_d;
        end
    end

    assign pixel_hit   = hit_p2_q;
    assign pixel_index = index_p2_q;

endmodule

// File: tb/tb_tank_sprite_renderer.sv
// Directed bench for tank_sprite_renderer (SCALE_SHIFT=1, ANIM_PERIOD=8).
// The sprite ROM is emulated by rom_fn. Expected addresses and indices are
// hand-derived from the scan coordinates. Entry = 0 when col==3 (transparent),
// otherwise {1, sy ^ col}.
module tb_tank_sprite_renderer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_start;
    logic [9:0] DrawX, DrawY, tank_x, tank_y;
    logic [1:0] tank_dir;
    logic       tank_moving, tank_alive;
    logic [6:0] rom_row;
    logic [3:0] rom_col;
    logic [4:0] rom_data;
    logic       pixel_hit;
    logic [4:0] pixel_index;

    int total = 0;
    int bad   = 0;

    tank_sprite_renderer #(.SCALE_SHIFT(1), .ANIM_PERIOD(8)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .tank_x(tank_x), .tank_y(tank_y),
        .tank_dir(tank_dir), .tank_moving(tank_moving), .tank_alive(tank_alive),
        .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
        .pixel_hit(pixel_hit), .pixel_index(pixel_index)
    );

    always #5 Clk = ~Clk;

    function automatic logic [4:0] rom_fn(input logic [3:0] sy, input logic [3:0] c);
        return (c == 4'd3) ? 5'd0 : {1'b1, sy ^ c};
    endfunction

    assign rom_data = rom_fn(rom_row[3:0], rom_col);

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_pulse(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d,
                               input logic alive, input logic mv);
        tank_x = x; tank_y = y; tank_dir = d; tank_alive = alive; tank_moving = mv;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; frame_start = 1'b0;
        DrawX = 10'd5; DrawY = 10'd7;
        tank_x = '0; tank_y = '0; tank_dir = '0; tank_moving = 1'b0; tank_alive = 1'b0;
        tick(); tick(); tick();
        total++;
        if (pixel_hit !== 1'b0 || pixel_index !== 5'd0) begin
            bad++;
            $display("FAIL reset_out hit=%0b idx=%0d want hit=0 idx=0", pixel_hit, pixel_index);
        end
        total++;
        if (rom_row !== 7'd0 || rom_col !== 4'd0) begin
            bad++;
            $display("FAIL reset_rom row=%0d col=%0d want row=0 col=0", rom_row, rom_col);
        end
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        int vx[8] = '{100, 131, 132, 106, 110,  99, 100, 117};
        int vy[8] = '{ 50,  81,  50,  52,  56,  50,  49,  70};
        int er[8] = '{ 32,  47,  -1,  33,  35,  -1,  -1,  42};
        int ec[8] = '{  0,  15,   0,   3,   5,   0,   0,   8};
        int eh[8] = '{  1,   1,   0,   0,   1,   0,   0,   1};
        int ei[8] = '{ 16,  16,   0,   0,  22,   0,   0,  18};
        frame_pulse(10'd100, 10'd50, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin DrawX = 10'(vx[i]); DrawY = 10'(vy[i]); end
            else begin DrawX = 10'd0; DrawY = 10'd0; end
            tick();
            if (i < 8 && er[i] >= 0) begin
                total++;
                if (rom_row !== 7'(er[i]) || rom_col !== 4'(ec[i])) begin
                    bad++;
                    $display("FAIL basic_rom[%0d] row=%0d col=%0d want row=%0d col=%0d",
                             i, rom_row, rom_col, er[i], ec[i]);
                end
            end
            if (i > 0) begin
                total++;
                if (pixel_hit !== 1'(eh[i-1]) || pixel_index !== 5'(ei[i-1])) begin
                    bad++;
                    $display("FAIL basic_pix[%0d] hit=%0b idx=%0d want hit=%0d idx=%0d",
                             i - 1, pixel_hit, pixel_index, eh[i-1], ei[i-1]);
                end
            end
        end
    endtask

    task automatic test_edge();
        int vx[8] = '{630, 639, 638, 636,   5,   5, 639, 635};
        int vy[8] = '{470, 479, 470, 475, 470, 479,   5, 473};
        int er[8] = '{  0,   4,   0,   2,  -1,  -1,  -1,   1};
        int ec[8] = '{  0,   4,   4,   3,   0,   0,   0,   2};
        int eh[8] = '{  1,   1,   1,   0,   0,   0,   0,   1};
        int ei[8] = '{ 16,  16,  20,   0,   0,   0,   0,  19};
        frame_pulse(10'd630, 10'd470, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin DrawX = 10'(vx[i]); DrawY = 10'(vy[i]); end
            else begin DrawX = 10'd0; DrawY = 10'd0; end
            tick();
            if (i < 8 && er[i] >= 0) begin
                total++;
                if (rom_row !== 7'(er[i]) || rom_col !== 4'(ec[i])) begin
                    bad++;
                    $display("FAIL edge_rom[%0d] row=%0d col=%0d want row=%0d col=%0d",
                             i, rom_row, rom_col, er[i], ec[i]);
                end
            end
            if (i > 0) begin
                total++;
                if (pixel_hit !== 1'(eh[i-1]) || pixel_index !== 5'(ei[i-1])) begin
                    bad++;
                    $display("FAIL edge_pix[%0d] hit=%0b idx=%0d want hit=%0d idx=%0d",
                             i - 1, pixel_hit, pixel_index, eh[i-1], ei[i-1]);
                end
            end
        end
    endtask

    task automatic test_dead();
        int vx[4] = '{100, 110, 131, 117};
        int vy[4] = '{ 50,  56,  81,  70};
        int er[4] = '{ 32,  35,  47,  42};
        int ec[4] = '{  0,   5,  15,   8};
        frame_pulse(10'd100, 10'd50, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin DrawX = 10'(vx[i]); DrawY = 10'(vy[i]); end
            else begin DrawX = 10'd0; DrawY = 10'd0; end
            tick();
            if (i < 4) begin
                total++;
                if (rom_row !== 7'(er[i]) || rom_col !== 4'(ec[i])) begin
                    bad++;
                    $display("FAIL dead_rom[%0d] row=%0d col=%0d want row=%0d col=%0d",
                             i, rom_row, rom_col, er[i], ec[i]);
                end
            end
            if (i > 0) begin
                total++;
                if (pixel_hit !== 1'b0 || pixel_index !== 5'd0) begin
                    bad++;
                    $display("FAIL dead_pix[%0d] hit=%0b idx=%0d want hit=0 idx=0",
                             i - 1, pixel_hit, pixel_index);
                end
            end
        end
    endtask

    // Each step issues np frame pulses with tank_moving=mv, then checks
    // rom_row at (100,50). Row 32 = dir 1 anim 0; row 48 = dir 1 anim 1.
    task automatic test_anim();
        int np[11] = '{ 1,  7,  1,  7,  1,  8,  1, 20,  1,  6,  1};
        int mv[11] = '{ 1,  1,  1,  1,  1,  1,  0,  0,  1,  1,  1};
        int ex[11] = '{32, 32, 48, 48, 32, 48, 48, 48, 48, 48, 32};
        for (int s = 0; s < 11; s++) begin
            repeat (np[s]) frame_pulse(10'd100, 10'd50, 2'd1, 1'b1, 1'(mv[s]));
            DrawX = 10'd100; DrawY = 10'd50;
            tick();
            total++;
            if (rom_row !== 7'(ex[s])) begin
                bad++;
                $display("FAIL anim_step[%0d] row=%0d want row=%0d", s, rom_row, ex[s]);
            end
        end
    endtask

    task automatic test_dir();
        // Mid-frame changes must not take effect
        tank_dir = 2'd2; tank_x = 10'd300;
        DrawX = 10'd100; DrawY = 10'd50;
        tick();
        total++;
        if (rom_row !== 7'd32) begin
            bad++;
            $display("FAIL dir_midframe row=%0d want row=32", rom_row);
        end
        DrawX = 10'd0; DrawY = 10'd0;
        tick();
        total++;
        if (pixel_hit !== 1'b1 || pixel_index !== 5'd16) begin
            bad++;
            $display("FAIL dir_midframe_pix hit=%0b idx=%0d want hit=1 idx=16", pixel_hit, pixel_index);
        end
        frame_pulse(10'd100, 10'd50, 2'd2, 1'b1, 1'b0);
        DrawX = 10'd100; DrawY = 10'd50;
        tick();
        total++;
        if (rom_row !== 7'd64) begin
            bad++;
            $display("FAIL dir_newframe row=%0d want row=64", rom_row);
        end
        // frame_start on the same edge as a live pixel: old direction used
        tank_dir = 2'd3; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        total++;
        if (rom_row !== 7'd64) begin
            bad++;
            $display("FAIL dir_coincide_old row=%0d want row=64", rom_row);
        end
        tick();
        total++;
        if (rom_row !== 7'd96) begin
            bad++;
            $display("FAIL dir_coincide_new row=%0d want row=96", rom_row);
        end
    endtask

    task automatic test_reset_mid();
        DrawX = 10'd100; DrawY = 10'd50;
        tick();
        DrawX = 10'd110; DrawY = 10'd56;
        tick();
        total++;
        if (pixel_hit !== 1'b1 || pixel_index !== 5'd16) begin
            bad++;
            $display("FAIL rstmid_before hit=%0b idx=%0d want hit=1 idx=16", pixel_hit, pixel_index);
        end
        Reset = 1'b1;
        tick();
        total++;
        if (pixel_hit !== 1'b0 || pixel_index !== 5'd0 || rom_row !== 7'd0 || rom_col !== 4'd0) begin
            bad++;
            $display("FAIL rstmid_flush hit=%0b idx=%0d row=%0d col=%0d want all 0",
                     pixel_hit, pixel_index, rom_row, rom_col);
        end
        tick();
        Reset = 1'b0;
        DrawX = 10'd100; DrawY = 10'd50;
        tick(); tick();
        total++;
        if (pixel_hit !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_unlatched hit=%0b want hit=0", pixel_hit);
        end
        frame_pulse(10'd100, 10'd50, 2'd2, 1'b1, 1'b0);
        DrawX = 10'd100; DrawY = 10'd50;
        tick();
        total++;
        if (rom_row !== 7'd64 || pixel_hit !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_s1 row=%0d hit=%0b want row=64 hit=0", rom_row, pixel_hit);
        end
        DrawX = 10'd0; DrawY = 10'd0;
        tick();
        total++;
        if (pixel_hit !== 1'b1 || pixel_index !== 5'd16) begin
            bad++;
            $display("FAIL rstmid_first hit=%0b idx=%0d want hit=1 idx=16", pixel_hit, pixel_index);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edge();
        test_dead();
        test_anim();
        test_dir();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a runaway simulation
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
